hssl_cfg_access_arbiter: RTL and testbench
==========================================

// Module: hssl_cfg_access_arbiter
// PURPOSE
//  Shares the register bank's single packet-side access port between NUM_REQ config requesters
//  (packet receiver, host-link bridge, on-chip sequencer). Round-robin arbitration, one access at a time.
//  Adds packet-read support: a read request issues a bank read, captures the data and emits a reply
//  packet keyed with the bank's reply key. Sits between the request sources and hssl_reg_bank.
// PARAMETERS
//  NUM_REQ        3     number of requesters (2..8)
//  ADR_BITS       8     register word-address width (section + register fields)
//  REPLY_TIMEOUT  1023  cycles a reply may wait for rpl_rdy_in before it is dropped (1..65535)
// PORTS
//  clk            in   1                 clock
//  resetn         in   1                 reset, asynchronous, active-low
//  req_vld_in     in   NUM_REQ           request valid, one per requester
//  req_rdy_out    out  NUM_REQ           request accepted (one-hot or zero)
//  req_wr_in      in   NUM_REQ           1 = write, 0 = read
//  req_addr_in    in   NUM_REQ*ADR_BITS  word address, requester i at [i*ADR_BITS +: ADR_BITS]
//  req_data_in    in   NUM_REQ*32        write data, requester i at [i*32 +: 32]
//  reg_addr_out   out  ADR_BITS          bank address
//  reg_wdata_out  out  32                bank write data
//  reg_wen_out    out  1                 bank write strobe (1 cycle)
//  reg_ren_out    out  1                 bank read strobe (1 cycle)
//  reg_rdata_in   in   32                bank read data, valid 1 cycle after reg_ren_out
//  reply_key_in   in   32                reply routing key from bank
//  rpl_key_out    out  32                reply packet key
//  rpl_data_out   out  32                reply packet payload (read data)
//  rpl_vld_out    out  1                 reply valid
//  rpl_rdy_in     in   1                 reply sink ready
//  rpl_drop_out   out  1                 1-cycle pulse: reply dropped on timeout
//  busy_out       out  1                 state != IDLE
// BEHAVIOUR
//  - States: IDLE, WRITE, READ, CAPTURE, REPLY. Reset -> IDLE; all outputs 0, rr pointer = NUM_REQ-1.
//  - Arbitration (IDLE only): grant = first i with req_vld_in[i] searching from ptr+1 modulo NUM_REQ.
//    req_rdy_out[grant] high combinationally in that cycle; handshake = vld&rdy; ptr <= grant.
//    On handshake latch addr, data, wr flag; go WRITE if wr else READ. req_rdy_out = 0 outside IDLE.
//  - WRITE: reg_wen_out = 1, reg_addr_out/reg_wdata_out = latched values; next IDLE.
//    Write throughput: 1 access per 2 cycles.
//  - READ: reg_ren_out = 1, reg_addr_out = latched addr; sample reply_key_in; next CAPTURE.
//  - CAPTURE: register reg_rdata_in into rpl_data_out; rpl_key_out = sampled key | {24'd0, addr} (addr
//    zero-extended to 32); next REPLY.
//  - REPLY: rpl_vld_out = 1, key/data stable until rpl_rdy_in. rpl_vld&rpl_rdy -> IDLE.
//    Timeout counter (16 bit) clears on REPLY entry, increments each REPLY cycle without rpl_rdy_in;
//    reaching REPLY_TIMEOUT -> rpl_drop_out pulse, rpl_vld_out low next cycle, -> IDLE.
//    rpl_rdy_in in the timeout cycle wins: reply delivered, no drop.
//  - reg_addr_out/reg_wdata_out hold last value when strobes low; reg_wen_out & reg_ren_out never both 1.
//  - Requests are not re-checked after acceptance; dropping req_vld_in later has no effect.
//  - Requester's wr/addr/data must be stable while vld high; a non-granted requester waits, never dropped.
//  - Reset mid-operation: returns to IDLE, pending access/reply abandoned, no strobe after reset release.
// TESTING
//  1. Single write: req0 vld wr addr 0x02 data 0xffff_fe00 -> rdy0 same cycle; next cycle
//     reg_wen_out=1 addr 0x02 wdata 0xffff_fe00; busy_out for exactly 1 cycle.
//  2. Read: req1 read addr 0x0f, reply_key_in 0xffff_fd00, bank returns 0x0000_0103 ->
//     rpl_vld_out 3 cycles after handshake, key 0xffff_fd0f, data 0x0000_0103.
//  3. Fairness: all 3 requesters hold vld with writes for 12 grants -> grant order 0,1,2,0,1,2,...;
//     each requester gets 4 grants.
//  4. Back-pressure: read with rpl_rdy_in low 10 cycles then high -> key/data stable throughout,
//     delivered once, no drop pulse; no requests accepted meanwhile.
//  5. Timeout: REPLY_TIMEOUT=15, rpl_rdy_in held low -> rpl_drop_out pulses after 15 REPLY cycles,
//     rpl_vld_out falls, next pending request granted the following cycle.
//  6. Reset during REPLY -> all outputs 0 asynchronously; after release first grant goes to requester 0.

Source files
------------

// File: rtl/hssl_cfg_access_arbiter_if.sv
// Request, register-bank and reply bundle between config requesters and the access arbiter.
// Latency: none, wires only.
// Backpressure: req_rdy_out per requester, rpl_rdy_in from the reply sink.
interface hssl_cfg_access_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int ADR_BITS = 8
);
  // requester side
  logic [NUM_REQ-1:0]          req_vld_in;
  logic [NUM_REQ-1:0]          req_rdy_out;
  logic [NUM_REQ-1:0]          req_wr_in;
  logic [NUM_REQ*ADR_BITS-1:0] req_addr_in;
  logic [NUM_REQ*32-1:0]       req_data_in;
  // register bank side
  logic [ADR_BITS-1:0]         reg_addr_out;
  logic [31:0]                 reg_wdata_out;
  logic                        reg_wen_out;
  logic                        reg_ren_out;
  logic [31:0]                 reg_rdata_in;
  logic [31:0]                 reply_key_in;
  // reply packet side
  logic [31:0]                 rpl_key_out;
  logic [31:0]                 rpl_data_out;
  logic                        rpl_vld_out;
  logic                        rpl_rdy_in;

  // arbiter view
  modport master (
    input  req_vld_in, req_wr_in, req_addr_in, req_data_in,
    output req_rdy_out,
    output reg_addr_out, reg_wdata_out, reg_wen_out, reg_ren_out,
    input  reg_rdata_in, reply_key_in,
    output rpl_key_out, rpl_data_out, rpl_vld_out,
    input  rpl_rdy_in
  );

  // requesters / bank / reply sink view
  modport slave (
    output req_vld_in, req_wr_in, req_addr_in, req_data_in,
    input  req_rdy_out,
    input  reg_addr_out, reg_wdata_out, reg_wen_out, reg_ren_out,
    output reg_rdata_in, reply_key_in,
    input  rpl_key_out, rpl_data_out, rpl_vld_out,
    output rpl_rdy_in
  );
endinterface

// File: rtl/hssl_cfg_access_arbiter.sv
// Round-robin arbiter sharing one register-bank port among NUM_REQ requesters, with read-reply packets.
// Latency: write strobe 1 cycle after accept; read reply valid 3 cycles after accept.
// Backpressure: one access in flight, requests held off until idle; reply waits for rpl_rdy_in up to REPLY_TIMEOUT cycles, then dropped.
module hssl_cfg_access_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADR_BITS      = 8,
  parameter int REPLY_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    resetn,
  hssl_cfg_access_arbiter_if.master bus,
  output logic                    rpl_drop_out,
  output logic                    busy_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_REPLY
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // round-robin pointer: last granted requester
  logic [PW-1:0]       r_ptr;
  // low for the first cycle after reset release so nothing is accepted while reset settles
  logic                r_run;

  logic [ADR_BITS-1:0] r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_key;
  logic [31:0]         r_rpl_key;
  logic [31:0]         r_rpl_data;
  logic [15:0]         r_cnt;

  logic                w_grant_vld;
  logic [PW-1:0]       w_grant;
  logic                w_sel_wr;
  logic [ADR_BITS-1:0] w_sel_addr;
  logic [31:0]         w_sel_data;
  logic [NUM_REQ-1:0]  w_req_rdy;
  logic                w_hs;
  logic                w_wen;
  logic                w_ren;
  logic                w_drop;
  logic                w_timeout;

  // Pick the first valid requester after r_ptr: pass 0 scans above the pointer, pass 1 wraps to 0..ptr.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_grant_vld && bus.req_vld_in[i] &&
            ((pass == 0) ? (i > int'(r_ptr)) : (i <= int'(r_ptr)))) begin
          w_grant_vld = 1'b1;
          w_grant     = PW'(i);
          w_sel_wr    = bus.req_wr_in[i];
          w_sel_addr  = bus.req_addr_in[i*ADR_BITS +: ADR_BITS];
          w_sel_data  = bus.req_data_in[i*32 +: 32];
        end
      end
    end
  end

  // A request is accepted only in IDLE; the ready is the combinational one-hot grant.
  assign w_hs = (r_state == S_IDLE) && r_run && w_grant_vld;

  // One-hot ready toward the granted requester.
  always_comb begin
    w_req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_rdy[i] = w_hs && (w_grant == PW'(i));
    end
  end

  // The reply has waited its full budget when the count reaches REPLY_TIMEOUT-1 in the current cycle.
  assign w_timeout = (r_cnt == 16'(REPLY_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode; an accepted reply beats a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_wen       = 1'b0;
    w_ren       = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_nxt = w_sel_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        w_wen       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_READ: begin
        w_ren       = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_REPLY;
      end
      S_REPLY: begin
        if (bus.rpl_rdy_in) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Arms acceptance one cycle after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Request latch, key sampling, reply capture and reply wait counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr      <= PW'(NUM_REQ - 1);
      r_addr     <= '0;
      r_wdata    <= '0;
      r_key      <= '0;
      r_rpl_key  <= '0;
      r_rpl_data <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_hs) begin
        r_ptr  <= w_grant;
        r_addr <= w_sel_addr;
        // write data only moves for writes so the bank's wdata bus stays quiet on reads
        if (w_sel_wr) begin
          r_wdata <= w_sel_data;
        end
      end
      if (r_state == S_READ) begin
        r_key <= bus.reply_key_in;
      end
      if (r_state == S_CAPTURE) begin
        r_rpl_data <= bus.reg_rdata_in;
        r_rpl_key  <= r_key | 32'(r_addr);
        r_cnt      <= '0;
      end
      if ((r_state == S_REPLY) && !bus.rpl_rdy_in && !w_timeout) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.req_rdy_out   = w_req_rdy;
  assign bus.reg_addr_out  = r_addr;
  assign bus.reg_wdata_out = r_wdata;
  assign bus.reg_wen_out   = w_wen;
  assign bus.reg_ren_out   = w_ren;
  assign bus.rpl_key_out   = r_rpl_key;
  assign bus.rpl_data_out  = r_rpl_data;
  assign bus.rpl_vld_out   = (r_state == S_REPLY);
  assign rpl_drop_out      = w_drop;
  assign busy_out          = (r_state != S_IDLE);

endmodule

// File: tb/tb_hssl_cfg_access_arbiter.sv
// Directed bench for hssl_cfg_access_arbiter: per-cycle vector table plus multi-cycle corner sequences.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: reply sink ready driven per vector.
module tb_hssl_cfg_access_arbiter;

  typedef struct packed {
    logic [2:0]  vld;
    logic [2:0]  wr;
    logic [23:0] addr;
    logic [95:0] data;
    logic [31:0] rdata;
    logic [31:0] key;
    logic        rpl_rdy;
  } in_t;

  typedef struct packed {
    logic [2:0]  rdy;
    logic        wen;
    logic        ren;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        vld;
    logic [31:0] rkey;
    logic [31:0] rdata;
    logic        drop;
    logic        busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic rpl_drop;
  logic busy;

  hssl_cfg_access_arbiter_if #(.NUM_REQ(3), .ADR_BITS(8)) bus ();

  hssl_cfg_access_arbiter #(
    .NUM_REQ      (3),
    .ADR_BITS     (8),
    .REPLY_TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .rpl_drop_out(rpl_drop),
    .busy_out    (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  out_t got;
  vec_t tbl[14];
  in_t  I0;
  int   ng;
  int   gidx;
  int   gcnt[3];
  int   bad;
  int   dropn;
  int   drops;
  logic vld_at_drop;

  function automatic in_t mi(logic [2:0] vld, logic [2:0] wr, logic [23:0] addr, logic [95:0] data,
                             logic [31:0] rdata, logic [31:0] key, logic rr);
    in_t v;
    v.vld = vld; v.wr = wr; v.addr = addr; v.data = data;
    v.rdata = rdata; v.key = key; v.rpl_rdy = rr;
    return v;
  endfunction

  function automatic out_t mo(logic [2:0] rdy, logic wen, logic ren, logic [7:0] addr, logic [31:0] wdata,
                              logic vld, logic [31:0] rkey, logic [31:0] rdata, logic drop, logic bsy);
    out_t o;
    o.rdy = rdy; o.wen = wen; o.ren = ren; o.addr = addr; o.wdata = wdata;
    o.vld = vld; o.rkey = rkey; o.rdata = rdata; o.drop = drop; o.busy = bsy;
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    bus.req_vld_in   = v.vld;
    bus.req_wr_in    = v.wr;
    bus.req_addr_in  = v.addr;
    bus.req_data_in  = v.data;
    bus.reg_rdata_in = v.rdata;
    bus.reply_key_in = v.key;
    bus.rpl_rdy_in   = v.rpl_rdy;
  endtask

  task automatic sample();
    got.rdy   = bus.req_rdy_out;
    got.wen   = bus.reg_wen_out;
    got.ren   = bus.reg_ren_out;
    got.addr  = bus.reg_addr_out;
    got.wdata = bus.reg_wdata_out;
    got.vld   = bus.rpl_vld_out;
    got.rkey  = bus.rpl_key_out;
    got.rdata = bus.rpl_data_out;
    got.drop  = rpl_drop;
    got.busy  = busy;
  endtask

  task automatic step(input in_t v);
    @(negedge clk);
    apply(v);
    #1;
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    I0 = mi(3'b000, 3'b000, 24'h0, 96'h0, 32'h0, 32'h0, 1'b0);

    // single write, read with reply, handshake blocking, round-robin order
    tbl[0]  = '{i: I0, o: mo(3'b000, 0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0, 0, 0)};
    tbl[1]  = '{i: mi(3'b001, 3'b001, 24'h000002, 96'hfffffe00, 0, 0, 0),
                o: mo(3'b001, 0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0, 0, 0)};
    tbl[2]  = '{i: I0, o: mo(3'b000, 1, 0, 8'h02, 32'hfffffe00, 0, 32'h0, 32'h0, 0, 1)};
    tbl[3]  = '{i: I0, o: mo(3'b000, 0, 0, 8'h02, 32'hfffffe00, 0, 32'h0, 32'h0, 0, 0)};
    tbl[4]  = '{i: mi(3'b010, 3'b000, 24'h000f00, 96'h0, 0, 0, 0),
                o: mo(3'b010, 0, 0, 8'h02, 32'hfffffe00, 0, 32'h0, 32'h0, 0, 0)};
    tbl[5]  = '{i: mi(3'b000, 3'b000, 24'h0, 96'h0, 0, 32'hffff_fd00, 0),
                o: mo(3'b000, 0, 1, 8'h0f, 32'hfffffe00, 0, 32'h0, 32'h0, 0, 1)};
    tbl[6]  = '{i: mi(3'b000, 3'b000, 24'h0, 96'h0, 32'h0000_0103, 0, 0),
                o: mo(3'b000, 0, 0, 8'h0f, 32'hfffffe00, 0, 32'h0, 32'h0, 0, 1)};
    tbl[7]  = '{i: mi(3'b001, 3'b001, 24'h000033, 96'h11, 32'hdeadbeef, 0, 0),
                o: mo(3'b000, 0, 0, 8'h0f, 32'hfffffe00, 1, 32'hffff_fd0f, 32'h103, 0, 1)};
    tbl[8]  = '{i: mi(3'b001, 3'b001, 24'h000033, 96'h11, 0, 0, 1),
                o: mo(3'b000, 0, 0, 8'h0f, 32'hfffffe00, 1, 32'hffff_fd0f, 32'h103, 0, 1)};
    tbl[9]  = '{i: mi(3'b001, 3'b001, 24'h000033, 96'h11, 0, 0, 0),
                o: mo(3'b001, 0, 0, 8'h0f, 32'hfffffe00, 0, 32'hffff_fd0f, 32'h103, 0, 0)};
    tbl[10] = '{i: I0, o: mo(3'b000, 1, 0, 8'h33, 32'h11, 0, 32'hffff_fd0f, 32'h103, 0, 1)};
    tbl[11] = '{i: mi(3'b111, 3'b111, 24'h424140, 96'h000000a2_000000a1_000000a0, 0, 0, 0),
                o: mo(3'b010, 0, 0, 8'h33, 32'h11, 0, 32'hffff_fd0f, 32'h103, 0, 0)};
    tbl[12] = '{i: mi(3'b101, 3'b111, 24'h424140, 96'h000000a2_000000a1_000000a0, 0, 0, 0),
                o: mo(3'b000, 1, 0, 8'h41, 32'ha1, 0, 32'hffff_fd0f, 32'h103, 0, 1)};
    tbl[13] = '{i: mi(3'b101, 3'b111, 24'h424140, 96'h000000a2_000000a1_000000a0, 0, 0, 0),
                o: mo(3'b100, 0, 0, 8'h41, 32'ha1, 0, 32'hffff_fd0f, 32'h103, 0, 0)};

    resetn = 1'b0;
    apply(I0);
    #3;
    sample();
    chk("reset_state", got, 112'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 14; k++) begin
      step(tbl[k].i);
      chk($sformatf("vec%0d", k), got, tbl[k].o);
    end

    // fairness: all three hold write requests for 12 grants
    ng = 0;
    for (int r = 0; r < 3; r++) gcnt[r] = 0;
    for (int c = 0; c < 60 && ng < 12; c++) begin
      step(mi(3'b111, 3'b111, 24'h424140, 96'h000000a2_000000a1_000000a0, 0, 0, 0));
      if (got.rdy != 3'b000) begin
        gidx = (got.rdy == 3'b001) ? 0 : (got.rdy == 3'b010) ? 1 : (got.rdy == 3'b100) ? 2 : 7;
        chk($sformatf("fair_grant%0d", ng), gidx, ng % 3);
        if (gidx < 3) gcnt[gidx]++;
        ng++;
      end
    end
    chk("fair_total", ng, 12);
    for (int r = 0; r < 3; r++) chk($sformatf("fair_count%0d", r), gcnt[r], 4);
    step(I0);
    chk("fair_last_wr", {got.wen, got.addr}, {1'b1, 8'h42});

    // back-pressure: reply held 10 cycles while requester 1 waits
    step(mi(3'b001, 3'b000, 24'h000055, 96'h0, 0, 0, 0));
    chk("bp_rdy", got.rdy, 3'b001);
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 0, 32'h1234_0000, 0));
    chk("bp_ren", {got.ren, got.wen, got.addr}, {1'b1, 1'b0, 8'h55});
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 32'hcafe_f00d, 0, 0));
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(mi(3'b010, 3'b010, 24'h006600, 96'h00000066_00000000, 0, 0, 0));
      if (!(got.vld && got.rkey == 32'h1234_0055 && got.rdata == 32'hcafe_f00d && !got.drop &&
            got.rdy == 3'b000)) bad++;
    end
    chk("bp_stable", bad, 0);
    step(mi(3'b010, 3'b010, 24'h006600, 96'h00000066_00000000, 0, 0, 1));
    chk("bp_deliver", {got.vld, got.drop, got.rdy}, {1'b1, 1'b0, 3'b000});
    step(mi(3'b010, 3'b010, 24'h006600, 96'h00000066_00000000, 0, 0, 0));
    chk("bp_after", {got.vld, got.drop, got.rdy}, {1'b0, 1'b0, 3'b010});
    step(I0);
    chk("bp_wr", {got.wen, got.addr, got.wdata}, {1'b1, 8'h66, 32'h66});

    // timeout: reply never accepted, requester 0 waiting
    step(mi(3'b100, 3'b000, 24'h770000, 96'h0, 0, 0, 0));
    chk("to_rdy", got.rdy, 3'b100);
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 0, 32'habcd_0000, 0));
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 32'h5a5a, 0, 0));
    dropn = 0;
    vld_at_drop = 1'b0;
    for (int n = 1; n <= 20 && dropn == 0; n++) begin
      step(mi(3'b001, 3'b001, 24'h000088, 96'h99, 0, 0, 0));
      if (got.drop) begin
        dropn = n;
        vld_at_drop = got.vld;
      end
    end
    chk("to_cycle", dropn, 15);
    chk("to_vld_at_drop", vld_at_drop, 1'b1);
    step(mi(3'b001, 3'b001, 24'h000088, 96'h99, 0, 0, 0));
    chk("to_next_grant", {got.vld, got.drop, got.rdy}, {1'b0, 1'b0, 3'b001});
    step(I0);
    chk("to_wr", {got.wen, got.addr}, {1'b1, 8'h88});

    // ready arriving in the timeout cycle delivers the reply
    step(mi(3'b010, 3'b000, 24'h001100, 96'h0, 0, 0, 0));
    chk("edge_rdy", got.rdy, 3'b010);
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 0, 32'h0, 0));
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 32'h1, 0, 0));
    drops = 0;
    for (int c = 0; c < 14; c++) begin
      step(I0);
      if (got.drop) drops++;
    end
    chk("edge_nodrop_before", drops, 0);
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 0, 0, 1));
    chk("edge_win", {got.vld, got.drop, got.rkey}, {1'b1, 1'b0, 32'h11});
    step(I0);
    chk("edge_idle", {got.vld, got.drop, got.busy}, 3'b000);

    // reset in the middle of a reply
    step(mi(3'b100, 3'b000, 24'h220000, 96'h0, 0, 0, 0));
    chk("rst_rd_rdy", got.rdy, 3'b100);
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 0, 32'hffff_0000, 0));
    step(mi(3'b000, 3'b000, 24'h0, 96'h0, 32'h77, 0, 0));
    step(I0);
    chk("rst_pre", {got.vld, got.rkey}, {1'b1, 32'hffff_0022});
    bus.req_vld_in  = 3'b011;
    bus.req_wr_in   = 3'b011;
    bus.req_addr_in = 24'h003130;
    bus.req_data_in = 96'h00000031_00000030;
    resetn = 1'b0;
    #1;
    sample();
    chk("rst_async", got, 112'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    sample();
    chk("rst_release_quiet", got, 112'h0);
    step(mi(3'b011, 3'b011, 24'h003130, 96'h00000031_00000030, 0, 0, 0));
    chk("rst_first_grant", {got.rdy, got.wen, got.ren, got.vld}, {3'b001, 1'b0, 1'b0, 1'b0});
    step(I0);
    chk("rst_wr", {got.wen, got.addr, got.wdata}, {1'b1, 8'h30, 32'h30});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
